// File: rtl/icache_assoc.sv
// Instruction cache with 1- or 2-way sets, multi-word lines, LRU replacement and burst fill.
// The miss address is latched at fill start. Hit/miss counters saturate at all-ones.
module icache_assoc #(
  parameter int SETS  = 8,
  parameter int WORDS = 2,
  parameter int WAYS  = 2,
  parameter int CNTW  = 32
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            imemREN,
  input  logic [31:0]     imemaddr,
  output logic [31:0]     imemload,
  output logic            ihit,
  input  logic            iflush,
  output logic            iREN,
  output logic [31:0]     iaddr,
  input  logic [31:0]     iload,
  input  logic            iwait,
  output logic [CNTW-1:0] hit_cnt,
  output logic [CNTW-1:0] miss_cnt
);
  localparam int OW = (WORDS > 1) ? $clog2(WORDS) : 0;
  localparam int CW = (OW > 0) ? OW : 1;
  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - OW - IW;

  if (WAYS != 1 && WAYS != 2) begin : g_bad_ways
    $error("icache_assoc: WAYS must be 1 or 2");
  end

  typedef enum logic {IDLE, FILL} state_t;
  state_t state, next_state;

  logic [SETS-1:0] valid_r [WAYS];
  logic [TW-1:0]   tag_r   [WAYS][SETS];
  logic [31:0]     data_r  [WAYS][SETS][WORDS];
  logic [SETS-1:0] lru_r;

  logic [TW-1:0] ltag;
  logic [IW-1:0] lidx;
  logic [CW-1:0] cnt;
  logic          victim;
  logic [CNTW-1:0] hit_cnt_r, miss_cnt_r;

  logic [TW-1:0] tag;
  logic [IW-1:0] idx;
  logic [CW-1:0] woff;
  logic          match, hit_way, pick, hit;
  logic          fill_start, fill_done, word_ok, last_word;
  logic          unused_bits;

  assign tag = imemaddr[31 -: TW];
  assign idx = imemaddr[2+OW +: IW];
  assign unused_bits = &{1'b0, imemaddr[1:0]};

  if (OW > 0) begin : g_multi
    assign woff  = imemaddr[2 +: OW];
    assign iaddr = (state == FILL) ? {ltag, lidx, cnt, 2'b00} : 32'h0;
  end else begin : g_single
    assign woff  = 1'b0;
    assign iaddr = (state == FILL) ? {ltag, lidx, 2'b00} : 32'h0;
  end

  always_comb begin
    match   = 1'b0;
    hit_way = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_r[w][idx] && tag_r[w][idx] == tag) begin
        match   = 1'b1;
        hit_way = 1'(w);
      end
    end
  end

  assign hit      = (state == IDLE) && imemREN && !iflush && match;
  assign ihit     = hit;
  assign imemload = hit ? data_r[hit_way][idx][woff] : 32'h0;

  // Victim: an empty way first (way0 preferred), otherwise the LRU way of the set.
  always_comb begin
    if (WAYS == 1)                   pick = 1'b0;
    else if (!valid_r[0][idx])       pick = 1'b0;
    else if (!valid_r[WAYS-1][idx])  pick = 1'b1;
    else                             pick = lru_r[idx];
  end

  // Memory handshake: iREN stays high for the whole fill; one word is transferred
  // on every rising edge where iREN=1 and iwait=0, and the word address then advances.
  assign iREN      = (state == FILL);
  assign word_ok   = (state == FILL) && !iwait;
  assign last_word = (cnt == CW'(WORDS - 1));

  always_comb begin
    next_state = state;
    fill_start = 1'b0;
    fill_done  = 1'b0;
    case (state)
      IDLE: begin
        if (!iflush && imemREN && !match) begin
          next_state = FILL;
          fill_start = 1'b1;
        end
      end
      FILL: begin
        if (iflush) begin
          next_state = IDLE;
        end else if (!iwait && last_word) begin
          next_state = IDLE;
          fill_done  = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      for (int w = 0; w < WAYS; w++) valid_r[w] <= '0;
      lru_r      <= '0;
      ltag       <= '0;
      lidx       <= '0;
      cnt        <= '0;
      victim     <= 1'b0;
      hit_cnt_r  <= '0;
      miss_cnt_r <= '0;
    end else begin
      state <= next_state;
      // A flush wins over validating a line that completes in the same cycle.
      if (iflush) begin
        for (int w = 0; w < WAYS; w++) valid_r[w] <= '0;
      end else if (fill_done) begin
        valid_r[victim][lidx] <= 1'b1;
      end
      if (fill_start) begin
        ltag   <= tag;
        lidx   <= idx;
        cnt    <= '0;
        victim <= pick;
        if (miss_cnt_r != '1) miss_cnt_r <= miss_cnt_r + 1'b1;
      end
      if (word_ok) cnt <= cnt + 1'b1;
      if (hit && WAYS == 2) lru_r[idx] <= ~hit_way;
      if (fill_done && WAYS == 2) lru_r[lidx] <= ~victim;
      if (hit && hit_cnt_r != '1) hit_cnt_r <= hit_cnt_r + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (word_ok) data_r[victim][lidx][cnt] <= iload;
    if (fill_done) tag_r[victim][lidx] <= ltag;
  end

  assign hit_cnt  = hit_cnt_r;
  assign miss_cnt = miss_cnt_r;
endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc (SETS=8, WORDS=2, WAYS=2): fills, hits, LRU eviction,
// stalled fill with address change, flush abort, counter saturation and async reset.
module tb_icache_assoc;
  localparam int WORDS = 2;
  localparam int CNTW  = 32;

  logic            CLK, nRST;
  logic            imemREN, iflush, iREN, iwait, ihit;
  logic [31:0]     imemaddr, imemload, iaddr, iload;
  logic [CNTW-1:0] hit_cnt, miss_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int stall_cnt = 0;
  int exp_hits = 0;
  int exp_miss = 0;
  logic [31:0] exp_q[$];

  icache_assoc #(.SETS(8), .WORDS(WORDS), .WAYS(2), .CNTW(CNTW)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .imemload(imemload), .ihit(ihit), .iflush(iflush), .iREN(iREN),
    .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h1234, ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // memory responder: stalls stall_cnt cycles, then returns words every cycle
  initial begin
    iwait = 1'b1;
    iload = 32'h0;
    forever begin
      @(posedge CLK); #1;
      if (iREN) begin
        if (stall_cnt > 0) begin
          iwait = 1'b1;
          stall_cnt--;
        end else begin
          iwait = 1'b0;
          iload = mem_word(iaddr);
        end
      end else begin
        iwait = 1'b1;
        iload = 32'h0;
      end
    end
  end

  // scoreboard: every accepted fill word address must match the expected queue
  initial begin
    forever begin
      @(posedge CLK);
      if (nRST && iREN && !iwait) begin
        if (exp_q.size() == 0) check("fill_addr_unexpected", {32'h0, iaddr}, 64'hFFFF_FFFF_FFFF_FFFF);
        else check("fill_addr", iaddr, exp_q.pop_front());
      end
    end
  end

  // driver: one fetch; exp_wait = cycles until ihit (0 = hit, WORDS+1+stall = miss)
  task automatic fetch(input logic [31:0] a, input int exp_wait, input string name);
    int n;
    n = 0;
    if (exp_wait > 0) begin
      for (int i = 0; i < WORDS; i++) exp_q.push_back({a[31:3], 3'b000} + 32'(4 * i));
      exp_miss++;
    end
    @(posedge CLK); #2;
    imemREN = 1'b1;
    imemaddr = a;
    #1;
    while (!ihit && n < 20) begin
      @(posedge CLK); #3;
      n++;
    end
    check({name, "_wait"}, n, exp_wait);
    check({name, "_data"}, imemload, mem_word(a));
    check({name, "_iren"}, iREN, 0);
    @(posedge CLK); #2;
    imemREN = 1'b0;
    exp_hits++;
  endtask

  task automatic flush_pulse();
    @(posedge CLK); #2;
    iflush = 1'b1;
    @(posedge CLK); #2;
    iflush = 1'b0;
  endtask

  initial begin
    int n;
    nRST = 1'b0;
    imemREN = 1'b0;
    imemaddr = 32'h0;
    iflush = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    check("rst_ihit", ihit, 0);
    check("rst_imemload", imemload, 0);
    check("rst_iren", iREN, 0);
    check("rst_iaddr", iaddr, 0);
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_miss_cnt", miss_cnt, 0);
    nRST = 1'b1;

    // cold miss then hit in the same line
    fetch(32'h040, 3, "t1");
    check("t1_miss_cnt", miss_cnt, exp_miss);
    fetch(32'h044, 0, "t2");
    check("t2_hit_cnt", hit_cnt, exp_hits);

    // flush in IDLE, then LRU eviction within set 0
    flush_pulse();
    fetch(32'h044, 3, "t3_after_flush");
    flush_pulse();
    fetch(32'h000, 3, "t3_fill0");
    fetch(32'h040, 3, "t3_fill1");
    fetch(32'h000, 0, "t3_touch0");
    fetch(32'h080, 3, "t3_evict");
    fetch(32'h000, 0, "t3_keep0");
    fetch(32'h040, 3, "t3_lost1");
    check("t3_miss_cnt", miss_cnt, exp_miss);
    check("t3_hit_cnt", hit_cnt, exp_hits);

    // stalled fill; request address changes and imemREN drops mid-fill
    stall_cnt = 3;
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    exp_miss++;
    @(posedge CLK); #2;
    imemREN = 1'b1;
    imemaddr = 32'h100;
    @(posedge CLK); #2;
    imemaddr = 32'h200;
    imemREN = 1'b0;
    #1;
    check("t4_iren_mid", iREN, 1);
    check("t4_iaddr_mid", iaddr, 32'h100);
    n = 0;
    while (iREN && n < 20) begin
      @(posedge CLK); #3;
      n++;
    end
    check("t4_fill_cycles", n, 5);
    fetch(32'h100, 0, "t4_hit100");
    fetch(32'h040, 0, "t4_hit040");

    // flush coinciding with the last fill word aborts the fill
    exp_q.push_back(32'h080);
    exp_q.push_back(32'h084);
    exp_miss++;
    @(posedge CLK); #2;
    imemREN = 1'b1;
    imemaddr = 32'h080;
    @(posedge CLK);
    @(posedge CLK); #2;
    iflush = 1'b1;
    imemREN = 1'b0;
    @(posedge CLK); #2;
    iflush = 1'b0;
    #1;
    check("t5_iren", iREN, 0);
    check("t5_ihit", ihit, 0);
    fetch(32'h100, 3, "t5_100_gone");
    fetch(32'h040, 3, "t5_040_gone");
    check("t5_miss_cnt", miss_cnt, exp_miss);
    check("t5_hit_cnt", hit_cnt, exp_hits);

    // hit counter saturation
    @(posedge CLK); #2;
    force dut.hit_cnt_r = '1;
    @(posedge CLK); #2;
    release dut.hit_cnt_r;
    check("t6_preload", hit_cnt, 32'hFFFF_FFFF);
    fetch(32'h040, 0, "t6_hit");
    check("t6_saturated", hit_cnt, 32'hFFFF_FFFF);

    // asynchronous reset in the middle of a fill
    stall_cnt = 5;
    @(posedge CLK); #2;
    imemREN = 1'b1;
    imemaddr = 32'h300;
    @(posedge CLK);
    @(posedge CLK); #2;
    check("t7_iren_mid", iREN, 1);
    nRST = 1'b0;
    #1;
    check("t7_iren_rst", iREN, 0);
    check("t7_iaddr_rst", iaddr, 0);
    check("t7_hit_cnt_rst", hit_cnt, 0);
    check("t7_miss_cnt_rst", miss_cnt, 0);
    imemREN = 1'b0;
    stall_cnt = 0;
    @(posedge CLK); #2;
    nRST = 1'b1;
    exp_miss = 0;
    exp_hits = 0;
    fetch(32'h040, 3, "t7_cold");
    check("t7_miss_cnt", miss_cnt, exp_miss);

    repeat (2) @(posedge CLK);
    check("exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
